// File: rtl/delay_line.sv
// delay_line: WIDTH-bit, DEPTH-stage enabled shift register with fill
// tracking and edge detection between the two youngest stages.
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             a,
    output logic [WIDTH-1:0]             z1,
    output logic [WIDTH-1:0]             z2,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic [WIDTH-1:0]             rise,
    output logic [WIDTH-1:0]             fall
);

    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  stage_q [DEPTH];
    logic [WIDTH-1:0]  stage_d [DEPTH];
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              edge_ok;

    // Next-state: flush clears everything, otherwise shift and count on en.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            stage_d[k] = stage_q[k];
        end
        fill_d = fill_q;
        if (flush) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage_d[k] = '0;
            end
            fill_d = '0;
        end else if (en) begin
            stage_d[0] = a;
            for (int k = 1; k < int'(DEPTH); k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (fill_q != FILL_W'(DEPTH)) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // State registers with synchronous reset taking priority over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage_q[k] <= '0;
            end
            fill_q <= '0;
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage_q[k] <= stage_d[k];
            end
            fill_q <= fill_d;
        end
    end

    // Edges are only meaningful once both compared stages hold real samples.
    always_comb begin
        edge_ok = (fill_q >= FILL_W'(2));
        rise    = stage_q[0] & ~stage_q[1] & {WIDTH{edge_ok}};
        fall    = ~stage_q[0] & stage_q[1] & {WIDTH{edge_ok}};
    end

    assign z1    = stage_q[0];
    assign z2    = stage_q[DEPTH-1];
    assign fill  = fill_q;
    assign valid = (fill_q == FILL_W'(DEPTH));

endmodule

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line in three configurations.
`timescale 1ns/1ps
module tb_delay_line;

    logic clk;
    int   checks;
    int   errors;

    // WIDTH=8, DEPTH=4
    logic       rst4, en4, fl4;
    logic [7:0] a4, z1_4, z2_4, rise4, fall4;
    logic       valid4;
    logic [2:0] fill4;

    // WIDTH=4, DEPTH=3
    logic       rst3, en3, fl3;
    logic [3:0] a3, z1_3, z2_3, rise3, fall3;
    logic       valid3;
    logic [1:0] fill3;

    // WIDTH=1, DEPTH=2
    logic       rst2, en2, fl2;
    logic [0:0] a2, z1_2, z2_2, rise2, fall2;
    logic       valid2;
    logic [1:0] fill2;

    logic       hist_a;
    logic       cur_a;
    logic       exp_rise, exp_fall;

    delay_line #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst4), .en(en4), .flush(fl4), .a(a4),
        .z1(z1_4), .z2(z2_4), .valid(valid4), .fill(fill4),
        .rise(rise4), .fall(fall4)
    );

    delay_line #(.WIDTH(4), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst3), .en(en3), .flush(fl3), .a(a3),
        .z1(z1_3), .z2(z2_3), .valid(valid3), .fill(fill3),
        .rise(rise3), .fall(fall3)
    );

    delay_line #(.WIDTH(1), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst2), .en(en2), .flush(fl2), .a(a2),
        .z1(z1_2), .z2(z2_2), .valid(valid2), .fill(fill2),
        .rise(rise2), .fall(fall2)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst4 = 1'b1; en4 = 1'b0; fl4 = 1'b0; a4 = 8'h00;
        rst3 = 1'b1; en3 = 1'b0; fl3 = 1'b0; a3 = 4'h0;
        rst2 = 1'b1; en2 = 1'b0; fl2 = 1'b0; a2 = 1'b0;
        @(negedge clk);
        cyc();

        // ---------------- WIDTH=8 DEPTH=4 ----------------
        chk("d4_rst_z1",    32'(z1_4),   32'h0);
        chk("d4_rst_z2",    32'(z2_4),   32'h0);
        chk("d4_rst_fill",  32'(fill4),  32'h0);
        chk("d4_rst_valid", 32'(valid4), 32'h0);
        chk("d4_rst_rise",  32'(rise4),  32'h0);

        rst4 = 1'b0; en4 = 1'b1; a4 = 8'h11; cyc();
        chk("d4_f1_z1",    32'(z1_4),   32'h11);
        chk("d4_f1_fill",  32'(fill4),  32'h1);
        chk("d4_f1_valid", 32'(valid4), 32'h0);
        a4 = 8'h22; cyc();
        chk("d4_f2_fill",  32'(fill4),  32'h2);
        a4 = 8'h33; cyc();
        chk("d4_f3_fill",  32'(fill4),  32'h3);
        chk("d4_f3_valid", 32'(valid4), 32'h0);
        chk("d4_f3_z2",    32'(z2_4),   32'h0);
        a4 = 8'h44; cyc();
        chk("d4_f4_z2",    32'(z2_4),   32'h11);
        chk("d4_f4_fill",  32'(fill4),  32'h4);
        chk("d4_f4_valid", 32'(valid4), 32'h1);
        a4 = 8'h55; cyc();
        chk("d4_sat_fill", 32'(fill4),  32'h4);
        chk("d4_sat_z2",   32'(z2_4),   32'h22);
        chk("d4_sat_valid",32'(valid4), 32'h1);

        // flush together with en on a full line
        fl4 = 1'b1; a4 = 8'h99; cyc();
        chk("d4_fl_z1",    32'(z1_4),   32'h0);
        chk("d4_fl_z2",    32'(z2_4),   32'h0);
        chk("d4_fl_fill",  32'(fill4),  32'h0);
        chk("d4_fl_valid", 32'(valid4), 32'h0);

        // gated enable pattern 1,0,1,0,1,0,1
        fl4 = 1'b0; en4 = 1'b1; a4 = 8'hA0; cyc();
        chk("d4_en_fill1", 32'(fill4),  32'h1);
        en4 = 1'b0; a4 = 8'hFF; cyc();
        chk("d4_hold_z1",  32'(z1_4),   32'hA0);
        chk("d4_hold_fill",32'(fill4),  32'h1);
        en4 = 1'b1; a4 = 8'hA1; cyc();
        chk("d4_en_z1",    32'(z1_4),   32'hA1);
        en4 = 1'b0; a4 = 8'hFF; cyc();
        en4 = 1'b1; a4 = 8'hA2; cyc();
        chk("d4_en_fill3", 32'(fill4),  32'h3);
        en4 = 1'b0; a4 = 8'hFF; cyc();
        chk("d4_hold_z2",  32'(z2_4),   32'h0);
        en4 = 1'b1; a4 = 8'hA3; cyc();
        chk("d4_en_z2",    32'(z2_4),   32'hA0);
        chk("d4_en_valid", 32'(valid4), 32'h1);
        en4 = 1'b0; a4 = 8'hEE; cyc();
        chk("d4_hold2_z2", 32'(z2_4),   32'hA0);
        chk("d4_hold2_z1", 32'(z1_4),   32'hA3);

        // reset beats flush and en mid-stream
        rst4 = 1'b1; fl4 = 1'b1; en4 = 1'b1; a4 = 8'h77; cyc();
        chk("d4_mrst_z1",   32'(z1_4),   32'h0);
        chk("d4_mrst_z2",   32'(z2_4),   32'h0);
        chk("d4_mrst_fill", 32'(fill4),  32'h0);
        chk("d4_mrst_valid",32'(valid4), 32'h0);
        chk("d4_mrst_fall", 32'(fall4),  32'h0);
        rst4 = 1'b0; fl4 = 1'b0;
        a4 = 8'h01; cyc();
        a4 = 8'h02; cyc();
        a4 = 8'h03; cyc();
        chk("d4_refill3_valid", 32'(valid4), 32'h0);
        a4 = 8'h04; cyc();
        chk("d4_refill4_valid", 32'(valid4), 32'h1);
        chk("d4_refill4_z2",    32'(z2_4),   32'h01);
        chk("d4_refill_rise",   32'(rise4),  32'h04);
        chk("d4_refill_fall",   32'(fall4),  32'h03);

        // ---------------- WIDTH=4 DEPTH=3 ----------------
        chk("d3_rst_fill", 32'(fill3), 32'h0);
        rst3 = 1'b0; en3 = 1'b1; a3 = 4'b0011; cyc();
        chk("d3_gate_rise", 32'(rise3), 32'h0);
        chk("d3_gate_fall", 32'(fall3), 32'h0);
        a3 = 4'b0101; cyc();
        chk("d3_rise", 32'(rise3), 32'h4);
        chk("d3_fall", 32'(fall3), 32'h2);
        chk("d3_f2_valid", 32'(valid3), 32'h0);
        a3 = 4'b0101; cyc();
        chk("d3_f3_valid", 32'(valid3), 32'h1);
        chk("d3_f3_z2",    32'(z2_3),   32'h3);
        chk("d3_same_rise",32'(rise3),  32'h0);
        a3 = 4'b1010; cyc();
        chk("d3_inv_rise", 32'(rise3),  32'hA);
        chk("d3_inv_fall", 32'(fall3),  32'h5);
        fl3 = 1'b1; en3 = 1'b0; cyc();
        chk("d3_fl_rise",  32'(rise3),  32'h0);
        chk("d3_fl_fall",  32'(fall3),  32'h0);
        chk("d3_fl_fill",  32'(fill3),  32'h0);
        chk("d3_fl_z1",    32'(z1_3),   32'h0);

        // ---------------- WIDTH=1 DEPTH=2 ----------------
        rst2 = 1'b0; en2 = 1'b1;
        hist_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cur_a = ((k / 4) % 2 == 0) ? 1'b1 : 1'b0;
            a2 = cur_a;
            cyc();
            chk("d2_z1",    32'(z1_2),   32'(cur_a));
            chk("d2_z2",    32'(z2_2),   32'(hist_a));
            chk("d2_valid", 32'(valid2), (k >= 1) ? 32'h1 : 32'h0);
            exp_rise = cur_a & ~hist_a & (k >= 1);
            exp_fall = ~cur_a & hist_a & (k >= 1);
            chk("d2_rise",  32'(rise2),  32'(exp_rise));
            chk("d2_fall",  32'(fall2),  32'(exp_fall));
            hist_a = cur_a;
        end
        chk("d2_fill_sat", 32'(fill2), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
